mux2_1_reg: RTL and testbench

- Registered 2:1 multiplexer with a configurable pipeline depth, used as a simple clocked datapath-select primitive in the stimulus/verification demo environment.
- Selects in0 or in1 each clock according to sel and presents the result on out after a fixed latency.
- Also provides which-input tracking and a saturating select-switch counter for observability.

---
 rtl/mux2_1_pkg.sv | 11 +
 rtl/mux2_1_stage.sv | 28 ++
 rtl/mux2_1_reg.sv | 93 +++++++++
 tb/tb_mux2_1_reg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux2_1_pkg.sv
// Shared constants for the registered 2:1 multiplexer and its pipeline stages.
package mux2_1_pkg;

  // Supported range of register stages between the inputs and out.
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  // Default width of the select-switch counter.
  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/mux2_1_stage.sv
// One pipeline stage of the registered mux: holds a {data, sel} pair and
// forwards it every clock. Reset clears data to RST_VAL and sel to 0.
module mux2_1_stage
  import mux2_1_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_s,
  input  logic             sel_s,
  output logic [WIDTH-1:0] data_r,
  output logic             sel_r
);

  // Capture the incoming pair on every edge; discard it at once on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= RST_VAL;
      sel_r  <= 1'b0;
    end else begin
      data_r <= data_s;
      sel_r  <= sel_s;
    end
  end

endmodule

// File: rtl/mux2_1_reg.sv
// Registered 2:1 multiplexer with a LATENCY-deep pipeline, which-input
// tracking (out_sel) and a saturating counter of select transitions.
module mux2_1_reg
  import mux2_1_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               LATENCY = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out,
  output logic             out_sel,
  output logic [CNT_W-1:0] switch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  // Refuse to build an unsupported pipeline depth.
  if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_bad_latency
    $error("mux2_1_reg: LATENCY must be within 1..4");
  end

  logic [WIDTH-1:0] mux_data_s;
  logic             mux_sel_s;
  logic [WIDTH-1:0] pipe_data_s [1:LATENCY];
  logic             pipe_sel_s  [1:LATENCY];
  logic             sel_hist_r;
  logic [CNT_W-1:0] switch_cnt_r;

  // Select decode: only a clean 1 picks in1, so X/Z on sel falls back to in0.
  always_comb begin
    mux_data_s = in0;
    mux_sel_s  = 1'b0;
    if (sel == 1'b1) begin
      mux_data_s = in1;
      mux_sel_s  = 1'b1;
    end else begin
      mux_data_s = in0;
      mux_sel_s  = 1'b0;
    end
  end

  // Chain of LATENCY stages; stage 1 takes the mux result, later ones shift.
  for (genvar i = 1; i <= LATENCY; i++) begin : g_stage
    logic [WIDTH-1:0] stage_data_s;
    logic             stage_sel_s;

    if (i == 1) begin : g_first
      assign stage_data_s = mux_data_s;
      assign stage_sel_s  = mux_sel_s;
    end else begin : g_next
      assign stage_data_s = pipe_data_s[i-1];
      assign stage_sel_s  = pipe_sel_s[i-1];
    end

    mux2_1_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .data_s (stage_data_s),
      .sel_s  (stage_sel_s),
      .data_r (pipe_data_s[i]),
      .sel_r  (pipe_sel_s[i])
    );
  end

  // Count edges where the decoded select differs from the previous edge's,
  // holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_hist_r   <= 1'b0;
      switch_cnt_r <= {CNT_W{1'b0}};
    end else begin
      sel_hist_r <= mux_sel_s;
      if ((mux_sel_s != sel_hist_r) && (switch_cnt_r != CNT_MAX)) begin
        switch_cnt_r <= switch_cnt_r + CNT_ONE;
      end
    end
  end

  assign out        = pipe_data_s[LATENCY];
  assign out_sel    = pipe_sel_s[LATENCY];
  assign switch_cnt = switch_cnt_r;

endmodule

// File: tb/tb_mux2_1_reg.sv
// Scoreboard bench for mux2_1_reg: four instances with different parameters
// share one stimulus bus; each phase targets one instance.
module tb_mux2_1_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [7:0] in0;
  logic [7:0] in1;

  // id0: W=1 L=1 CNT_W=16, id1: W=8 L=3, id2: W=1 L=1 CNT_W=2, id3: W=8 L=4 RST_VAL=5A
  logic        out_a, osel_a;  logic [15:0] cnt_a;
  logic [7:0]  out_b;          logic osel_b;  logic [15:0] cnt_b;
  logic        out_c, osel_c;  logic [1:0]  cnt_c;
  logic [7:0]  out_d;          logic osel_d;  logic [15:0] cnt_d;

  always #5 clk = ~clk;

  mux2_1_reg #(.WIDTH(1), .LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .sel(sel), .in0(in0[0]), .in1(in1[0]),
    .out(out_a), .out_sel(osel_a), .switch_cnt(cnt_a));

  mux2_1_reg #(.WIDTH(8), .LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .sel(sel), .in0(in0), .in1(in1),
    .out(out_b), .out_sel(osel_b), .switch_cnt(cnt_b));

  mux2_1_reg #(.WIDTH(1), .LATENCY(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .sel(sel), .in0(in0[0]), .in1(in1[0]),
    .out(out_c), .out_sel(osel_c), .switch_cnt(cnt_c));

  mux2_1_reg #(.WIDTH(8), .LATENCY(4), .RST_VAL(8'h5A)) u_d (
    .clk(clk), .rst(rst), .sel(sel), .in0(in0), .in1(in1),
    .out(out_d), .out_sel(osel_d), .switch_cnt(cnt_d));

  typedef struct {
    int         edge_no;
    int         id;
    logic [7:0] eout;
    logic       esel;
    logic [15:0] ecnt;
    bit         chk_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   n_chk    = 0;
  int   n_err    = 0;

  // Number of rising edges seen so far.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] act_out(input int id);
    case (id)
      0:       return {7'b0000000, out_a};
      1:       return out_b;
      2:       return {7'b0000000, out_c};
      default: return out_d;
    endcase
  endfunction

  function automatic logic act_sel(input int id);
    case (id)
      0:       return osel_a;
      1:       return osel_b;
      2:       return osel_c;
      default: return osel_d;
    endcase
  endfunction

  function automatic logic [15:0] act_cnt(input int id);
    case (id)
      0:       return cnt_a;
      1:       return cnt_b;
      2:       return {14'h0000, cnt_c};
      default: return cnt_d;
    endcase
  endfunction

  function automatic logic [7:0] rv_of(input int id);
    return (id == 3) ? 8'h5A : 8'h00;
  endfunction

  task automatic check(input string name, input int id, input logic [15:0] act,
                       input logic [15:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s dut%0d edge %0d: got %h expected %h", name, id, edge_cnt, act, exp_v);
    end
  endtask

  // Monitor: after each rising edge, pop and compare every entry due by now.
  always @(negedge clk) begin : monitor
    exp_t e;
    while ((sb_q.size() > 0) && (sb_q[0].edge_no <= edge_cnt)) begin
      e = sb_q.pop_front();
      check("out", e.id, {8'h00, act_out(e.id)}, {8'h00, e.eout});
      check("out_sel", e.id, {15'h0000, act_sel(e.id)}, {15'h0000, e.esel});
      if (e.chk_cnt) check("switch_cnt", e.id, act_cnt(e.id), e.ecnt);
    end
  end

  // Drive one sample and queue the response due LATENCY-1 edges after it is sampled.
  task automatic vec(input int id, input int lat, input logic s, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] eo, input logic es,
                     input logic [15:0] ec, input bit cc);
    sel = s;
    in0 = a;
    in1 = b;
    sb_q.push_back('{edge_cnt + lat, id, eo, es, ec, cc});
    @(posedge clk);
    #2;
  endtask

  // Mid-cycle reset pulse: immediate check, discard in-flight expectations,
  // then expect RST_VAL until the first new sample has crossed the pipeline.
  task automatic phase_reset(input int id, input int lat);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_out", id, {8'h00, act_out(id)}, {8'h00, rv_of(id)});
    check("rst_out_sel", id, {15'h0000, act_sel(id)}, 16'h0000);
    check("rst_cnt", id, act_cnt(id), 16'h0000);
    while ((sb_q.size() > 0) && (sb_q[sb_q.size()-1].edge_no > edge_cnt)) void'(sb_q.pop_back());
    sb_q.push_back('{edge_cnt + 1, id, rv_of(id), 1'b0, 16'h0000, 1'b1});
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 1; k < lat; k++) sb_q.push_back('{edge_cnt + k, id, rv_of(id), 1'b0, 16'h0000, 1'b0});
  endtask

  // Hard stop if the run never reaches its summary.
  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    int         hold;

    rst = 1'b1;
    sel = 1'b0;
    in0 = 8'h00;
    in1 = 8'h00;
    #1;
    for (int id = 0; id < 4; id++) begin
      check("por_out", id, {8'h00, act_out(id)}, {8'h00, rv_of(id)});
      check("por_cnt", id, act_cnt(id), 16'h0000);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Phase A: L=1 basic select, then reset while sel=1/in1=1, then data tracking.
    vec(0, 1, 1'b1, 8'h00, 8'hFF, 8'h01, 1'b1, 16'd1, 1'b1);
    vec(0, 1, 1'b1, 8'h00, 8'hFF, 8'h01, 1'b1, 16'd1, 1'b1);
    phase_reset(0, 1);
    repeat (3) vec(0, 1, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 16'd0, 1'b1);
    repeat (3) vec(0, 1, 1'b1, 8'h00, 8'hFF, 8'h01, 1'b1, 16'd1, 1'b1);
    vec(0, 1, 1'b0, 8'h01, 8'hFF, 8'h01, 1'b0, 16'd2, 1'b1);
    vec(0, 1, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 16'd2, 1'b1);
    vec(0, 1, 1'b0, 8'h01, 8'hFF, 8'h01, 1'b0, 16'd2, 1'b1);
    vec(0, 1, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 16'd2, 1'b1);

    // Phase B: L=3, a single A5 pulse on in1 must appear for exactly one cycle.
    phase_reset(1, 3);
    vec(1, 3, 1'b0, 8'h3C, 8'hFF, 8'h3C, 1'b0, 16'd0, 1'b0);
    vec(1, 3, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1, 16'd0, 1'b0);
    vec(1, 3, 1'b1, 8'h3C, 8'hA5, 8'hA5, 1'b1, 16'd0, 1'b0);
    vec(1, 3, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1, 16'd0, 1'b0);
    vec(1, 3, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1, 16'd0, 1'b0);
    vec(1, 3, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1, 16'd0, 1'b0);

    // Phase C: CNT_W=2, toggling sel saturates the counter at 3.
    phase_reset(2, 1);
    vec(2, 1, 1'b1, 8'h00, 8'h01, 8'h01, 1'b1, 16'd1, 1'b1);
    vec(2, 1, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 16'd2, 1'b1);
    vec(2, 1, 1'b1, 8'h00, 8'h01, 8'h01, 1'b1, 16'd3, 1'b1);
    vec(2, 1, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 16'd3, 1'b1);
    vec(2, 1, 1'b1, 8'h00, 8'h01, 8'h01, 1'b1, 16'd3, 1'b1);
    vec(2, 1, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 16'd3, 1'b1);
    repeat (2) vec(2, 1, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 16'd3, 1'b1);

    // Phase D: L=4, random stream with holds, reset mid-pipeline, fresh samples.
    phase_reset(3, 4);
    for (int i = 0; i < 20; i++) begin
      s    = 1'($urandom_range(0, 1));
      a    = 8'($urandom);
      b    = 8'($urandom);
      hold = int'($urandom_range(0, 3));
      repeat (hold + 1) vec(3, 4, s, a, b, s ? b : a, s, 16'd0, 1'b0);
    end
    phase_reset(3, 4);
    vec(3, 4, 1'b1, 8'h11, 8'hC3, 8'hC3, 1'b1, 16'd0, 1'b0);
    vec(3, 4, 1'b0, 8'h7E, 8'h22, 8'h7E, 1'b0, 16'd0, 1'b0);
    vec(3, 4, 1'b1, 8'h00, 8'h96, 8'h96, 1'b1, 16'd0, 1'b0);
    repeat (4) vec(3, 4, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0, 1'b0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_drain", -1, 16'(sb_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
